// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master (modes 0-3) driving one of NUM_SS slave selects.
// Optional feature macro SPI_MASTER_MULTI_LSB_FIRST_EN adds a per-command lsb_first input.
module spi_master_multi #(
  parameter int  DATA_W  = 8,
  parameter int  NUM_SS  = 2,
  parameter int  CLK_DIV = 2,
  localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EC_W  = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [EC_W-1:0]   edge_cnt_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_r;

  logic              lsb_first_s;
  logic              sel_ok_s;
  logic              accept_s;
  logic              div_end_s;
  logic              lead_s;
  logic              last_s;
  logic              sample_s;
  logic              shift_s;
  logic              next_mosi_s;
  logic [DATA_W-1:0] tx_word_s;

  // Bit-order helper: reverses a word when rev is set, identity otherwise.
  function automatic logic [DATA_W-1:0] bit_order(input logic [DATA_W-1:0] w, input logic rev);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = rev ? w[DATA_W-1-i] : w[i];
    end
    return r;
  endfunction

`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
  assign lsb_first_s = lsb_first;
`else
  assign lsb_first_s = 1'b0;
`endif

  // A power-of-two slave count makes every index legal.
  generate
    if (NUM_SS == (1 << SS_W)) begin : g_sel_full
      assign sel_ok_s = 1'b1;
    end else begin : g_sel_part
      assign sel_ok_s = (ss_sel < SS_W'(NUM_SS));
    end
  endgenerate

  assign accept_s    = start && ready && sel_ok_s;
  assign div_end_s   = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign lead_s      = ~edge_cnt_r[0];
  assign last_s      = (edge_cnt_r == EC_W'(2 * DATA_W - 1));
  assign sample_s    = lead_s ^ cpha_r;
  // cpha=1 re-presents the current MSB on each leading edge; cpha=0 moves to the next bit.
  assign shift_s     = cpha_r ? lead_s : (~lead_s & ~last_s);
  assign next_mosi_s = cpha_r ? tx_shift_r[DATA_W-1] : tx_shift_r[DATA_W-2];
  assign tx_word_s   = bit_order(tx_data, lsb_first_s);

  // Control FSM, SCLK divider, shift registers and every registered output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      ready      <= 1'b1;
      rx_valid   <= 1'b0;
      rx_data    <= {DATA_W{1'b0}};
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      ss_n       <= {NUM_SS{1'b1}};
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      lsb_r      <= 1'b0;
      div_cnt_r  <= {DIV_W{1'b0}};
      edge_cnt_r <= {EC_W{1'b0}};
      tx_shift_r <= {DATA_W{1'b0}};
      rx_shift_r <= {DATA_W{1'b0}};
    end else begin
      rx_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          sclk <= cpol_r;
          if (accept_s) begin
            tx_shift_r <= tx_word_s;
            mosi       <= tx_word_s[DATA_W-1];
            cpol_r     <= cpol;
            cpha_r     <= cpha;
            lsb_r      <= lsb_first_s;
            sclk       <= cpol;
            ss_n       <= ~(NUM_SS'(1'b1) << ss_sel);
            ready      <= 1'b0;
            div_cnt_r  <= {DIV_W{1'b0}};
            edge_cnt_r <= {EC_W{1'b0}};
            rx_shift_r <= {DATA_W{1'b0}};
            state_r    <= LEAD;
          end else begin
            div_cnt_r <= {DIV_W{1'b0}};
          end
        end
        LEAD: begin
          if (div_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            state_r   <= XFER;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        XFER: begin
          if (div_end_s) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            sclk       <= ~sclk;
            edge_cnt_r <= edge_cnt_r + EC_W'(1);
            if (sample_s) begin
              rx_shift_r <= {rx_shift_r[DATA_W-2:0], miso};
            end
            if (shift_s) begin
              mosi       <= next_mosi_s;
              tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            end
            if (last_s) begin
              edge_cnt_r <= {EC_W{1'b0}};
              state_r    <= TRAIL;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        TRAIL: begin
          sclk <= cpol_r;
          if (div_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            ss_n      <= {NUM_SS{1'b1}};
            rx_data   <= bit_order(rx_shift_r, lsb_r);
            rx_valid  <= 1'b1;
            ready     <= 1'b1;
            state_r   <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          ready     <= 1'b1;
          ss_n      <= {NUM_SS{1'b1}};
          div_cnt_r <= {DIV_W{1'b0}};
        end
      endcase
    end
  end

endmodule
